// File: rtl/mdu_pkg.sv
// Shared constants for the E-stage multiply/divide unit: op encodings,
// default operand width and the latency counter sizing helper.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } mdu_op_e;

  // The counter holds (latency-1), so clog2 of the longest latency is enough;
  // keep at least one bit so single-cycle configurations still elaborate.
  function automatic int cnt_width(input int mult_cycles, input int div_cycles);
    int longest;
    int w;
    longest = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
    w = $clog2(longest);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mdu_div.sv
// Combinational signed/unsigned divider returning quotient and remainder,
// with the MIPS corner cases (truncation toward zero, divide by zero flag).
module mdu_div
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             div_zero
);

  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] r_mag;

  // Divide magnitudes, then restore signs: quotient negative when operand
  // signs differ, remainder follows the dividend. The -2^(W-1) / -1 case
  // falls out naturally: magnitude quotient 2^(W-1) wraps to -2^(W-1), rem 0.
  always_comb begin
    neg_a    = is_signed & a[WIDTH-1];
    neg_b    = is_signed & b[WIDTH-1];
    mag_a    = neg_a ? -a : a;
    mag_b    = neg_b ? -b : b;
    div_zero = (b == '0);
    q_mag    = '0;
    r_mag    = '0;
    if (!div_zero) begin
      q_mag = mag_a / mag_b;
      r_mag = mag_a % mag_b;
    end
    quot = (neg_a ^ neg_b) ? -q_mag : q_mag;
    rem  = neg_a ? -r_mag : r_mag;
  end

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit. Owns HI/LO, computes mult/div results at
// issue into pending registers and commits them after a fixed busy latency.
module e_mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH       = MDU_WIDTH,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = cnt_width(MULT_CYCLES, DIV_CYCLES);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e                   state;
  logic [CW-1:0]            cnt;
  logic                     pend_wr;
  logic [WIDTH-1:0]         pend_hi;
  logic [WIDTH-1:0]         pend_lo;

  logic signed [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0]        prod_u;
  logic [WIDTH-1:0]          quot;
  logic [WIDTH-1:0]          rem;
  logic                      div_zero;

  logic                      is_md;
  logic                      res_wr;
  logic [CW-1:0]             lat;
  logic [WIDTH-1:0]          res_hi;
  logic [WIDTH-1:0]          res_lo;
  logic                      accept_md;

  assign prod_s = $signed({{WIDTH{src_a[WIDTH-1]}}, src_a}) *
                  $signed({{WIDTH{src_b[WIDTH-1]}}, src_b});
  assign prod_u = {{WIDTH{1'b0}}, src_a} * {{WIDTH{1'b0}}, src_b};

  mdu_div #(.WIDTH(WIDTH)) u_div (
    .a         (src_a),
    .b         (src_b),
    .is_signed (op == OP_DIV),
    .quot      (quot),
    .rem       (rem),
    .div_zero  (div_zero)
  );

  // Decode the op into its result, latency and whether commit writes HI/LO.
  always_comb begin
    is_md  = 1'b0;
    res_wr = 1'b0;
    lat    = '0;
    res_hi = '0;
    res_lo = '0;
    case (op)
      OP_MULT: begin
        is_md            = 1'b1;
        res_wr           = 1'b1;
        lat              = CW'(MULT_CYCLES - 1);
        {res_hi, res_lo} = prod_s;
      end
      OP_MULTU: begin
        is_md            = 1'b1;
        res_wr           = 1'b1;
        lat              = CW'(MULT_CYCLES - 1);
        {res_hi, res_lo} = prod_u;
      end
      OP_DIV, OP_DIVU: begin
        is_md  = 1'b1;
        res_wr = !div_zero;
        lat    = CW'(DIV_CYCLES - 1);
        res_hi = rem;
        res_lo = quot;
      end
      default: ;
    endcase
  end

  assign accept_md = (state == IDLE) && start && is_md;

  // Control FSM: issue, count down the latency, commit; MTHI/MTLO write directly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      pend_wr <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_md) begin
            state   <= BUSY;
            busy    <= 1'b1;
            cnt     <= lat;
            pend_wr <= res_wr;
          end else if (start && (op == OP_MTHI)) begin
            hi <= src_a;
          end else if (start && (op == OP_MTLO)) begin
            lo <= src_a;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            state   <= IDLE;
            busy    <= 1'b0;
            pend_wr <= 1'b0;
            if (pend_wr) begin
              hi <= pend_hi;
              lo <= pend_lo;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pending result capture; stale contents are harmless since pend_wr gates commit.
  always_ff @(posedge clk) begin
    if (accept_md) begin
      pend_hi <= res_hi;
      pend_lo <= res_lo;
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: latency, arithmetic corner cases, async reset
// mid-operation and start-while-busy handling.
module tb_e_mdu;
  import mdu_pkg::*;

  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         busy;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_cmp = 0;
  int n_err = 0;
  int illegal = 0;
  int nb;

  e_mdu #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  // Hazard-unit contract monitor: a start presented while busy is illegal.
  always @(negedge clk) begin
    if (start && busy) begin
      illegal++;
      $display("note: start presented while busy (op=%0d)", op);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts busy cycles sampled at negedges; returns at the first negedge with busy low.
  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) n++;
      else break;
    end
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    #2 reset = 1'b1;

    // MULT -2 * 3
    issue(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    count_busy(nb);
    chk("mult_busy", nb, MC);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);

    // MULTU max * max
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    count_busy(nb);
    chk("multu_busy", nb, MC);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);

    // DIV -7 / 2
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    count_busy(nb);
    chk("div_busy", nb, DC);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    // DIVU same operands
    issue(OP_DIVU, 32'hFFFF_FFF9, 32'd2);
    count_busy(nb);
    chk("divu_busy", nb, DC);
    chk("divu_lo", lo, 32'h7FFF_FFFC);
    chk("divu_hi", hi, 32'h0000_0001);

    // MTLO 0, MTHI 0x12345678
    issue(OP_MTLO, 32'd0, 32'd0);
    @(negedge clk);
    chk("mtlo0_lo", lo, 0);
    issue(OP_MTHI, 32'h1234_5678, 32'd0);
    @(negedge clk);
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mthi_busy", busy, 0);

    // DIV by zero: full latency, HI/LO unchanged
    issue(OP_DIV, 32'd100, 32'd0);
    count_busy(nb);
    chk("divz_busy", nb, DC);
    chk("divz_hi", hi, 32'h1234_5678);
    chk("divz_lo", lo, 0);

    // Signed overflow
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    count_busy(nb);
    chk("ovf_busy", nb, DC);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 0);

    // Reset mid-operation at busy cycle 3
    issue(OP_MTHI, 32'hAAAA_5555, 32'd0);
    @(negedge clk);
    chk("mthiA_hi", hi, 32'hAAAA_5555);
    issue(OP_MULT, 32'd3, 32'd4);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_hi", hi, 0);
    chk("midrst_lo", lo, 0);
    #2 reset = 1'b1;
    issue(OP_MTLO, 32'd5, 32'd0);
    @(negedge clk);
    chk("mtlo5_lo", lo, 32'd5);
    chk("mtlo5_busy", busy, 0);
    repeat (6) @(negedge clk);
    chk("discard_lo", lo, 32'd5);
    chk("discard_hi", hi, 0);

    // MULT 6*7 with MTHI start held throughout busy; accepted once busy falls
    @(negedge clk);
    start = 1'b1;
    op    = OP_MULT;
    src_a = 32'd6;
    src_b = 32'd7;
    @(posedge clk);
    #1;
    op    = OP_MTHI;
    src_a = 32'h0000_DEAD;
    count_busy(nb);
    chk("hold_busy", nb, MC);
    chk("hold_hi", hi, 0);
    chk("hold_lo", lo, 32'd42);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("b2b_hi", hi, 32'h0000_DEAD);
    chk("b2b_busy", busy, 0);
    chk("illegal_starts", illegal, MC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/e_mdu.md
# e_mdu

Parametrised multi-cycle multiply/divide unit for the E stage of the pipelined MIPS core. It owns the HI/LO register pair and executes mult/multu/div/divu with configurable latency, plus single-cycle mthi/mtlo. It reports `busy` so the hazard unit can stall dependent md instructions in D. HI/LO reads for mfhi/mflo come straight from the `hi`/`lo` outputs, forwarded into the E-stage result path.

## Interface
- `WIDTH`, 32: operand width; HI and LO are each `WIDTH` bits.
- `MULT_CYCLES`, 5: busy cycles for mult/multu, ≥1.
- `DIV_CYCLES`, 10: busy cycles for div/divu, ≥1.
- `clk` input 1: the single clock.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: issue the op on `op` this cycle (E-stage instruction is an md op, not flushed).
- `op` input 3: operation code, from the `mdu_pkg` encodings (MULT, MULTU, DIV, DIVU, MTHI, MTLO).
- `src_a` input WIDTH: rs value after forwarding (MF_ALUA_E).
- `src_b` input WIDTH: rt value after forwarding (MF_ALUB_E).
- `busy` output 1: an operation is in flight (registered).
- `hi` output WIDTH: architectural HI.
- `lo` output WIDTH: architectural LO.

## Operation
- States:
  - IDLE: `busy`=0.
  - BUSY: `busy`=1.
- IDLE with `start` and a mult/div op:
  - Latch the computed result into pending_hi/pending_lo.
  - Load the counter with (latency−1).
  - Go to BUSY.
- BUSY:
  - Counter ≠ 0: decrement.
  - Counter = 0: commit pending to HI/LO and return to IDLE.
- MTHI/MTLO with `start` in IDLE: write `src_a` to HI or LO at that edge. No BUSY, `busy` stays 0.
- `start` while BUSY is ignored for every op. The hazard unit guarantees this does not happen, and the bench checks for it with an assertion.
- Arithmetic:
  - MULT is signed and MULTU unsigned. The full 2·WIDTH-bit product goes to HI (upper half) and LO (lower half).
  - DIV is signed: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
  - DIVU is unsigned.
  - Signed overflow (−2^(WIDTH−1) / −1): LO = −2^(WIDTH−1), HI = 0.
  - Division by zero: the full DIV_CYCLES of busy still occur, and HI/LO are left unchanged at commit.
- Result computation is combinational at issue, held in pending registers. An iterative datapath is permitted only if it keeps identical external timing.
- Reset (any time, including mid-operation):
  - state = IDLE, counter = 0, pending discarded.
  - `hi` = 0, `lo` = 0, `busy` = 0.

## Timing
- `start` sampled at edge E0 for a mult/div op with latency N:
  - `busy` is high for exactly N cycles, from after E0 through E_N.
  - HI/LO update at edge E_N.
  - In the cycle after E_N, new `hi`/`lo` are visible and `busy` = 0.
- Back-to-back: a new `start` is accepted in the first cycle with `busy` = 0, so the minimum issue interval is N+1 cycles.
- MTHI/MTLO: value is visible on `hi`/`lo` the cycle after the `start` edge.
- `busy` does not cover the issue cycle itself. The hazard unit stalls D on an md instruction when (E has an md op with `start`) or `busy`.
- Reset deassertion is asynchronous to the block. The first `start` is honoured at the first edge with `reset` high.

## Structure
- `mdu_pkg` holds:
  - the `op` encodings as localparams/enum;
  - the `WIDTH` default;
  - a counter-width helper `$clog2(max(MULT_CYCLES, DIV_CYCLES))`, minimum 1 bit.
- Control_Unit decodes `op` and `start` from IR_E using `mdu_pkg` constants.
- No sub-module is required. The signed/unsigned divide with its corner cases may be split into `mdu_div`, a combinational block returning {rem, quot}, to keep the FSM file small.

## Test plan
- Reset, then MULT with a=0xFFFFFFFE (−2), b=3 → `busy` high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU with a=0xFFFFFFFF, b=0xFFFFFFFF → after 5 cycles, hi=0xFFFFFFFE, lo=0x00000001.
- DIV with a=−7 (0xFFFFFFF9), b=2 → after 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU with the same operands → lo=0x7FFFFFFC, hi=1.
- MTHI 0x12345678, then DIV by b=0 → `busy` high 10 cycles; hi stays 0x12345678, lo stays 0. Also DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- Start MULT, assert `reset` low at busy cycle 3 → `busy`, `hi`, `lo` all 0 immediately. After release, MTLO 5 → lo=5 next cycle, `busy` stays 0.
- Issue MULT with a second `start`(MTHI) held during BUSY → MTHI ignored and the assertion fires. A `start` on the first cycle after `busy` falls is accepted.
